serial_adder: RTL and testbench

Bit-serial adder that adds two WIDTH-bit unsigned operands LSB-first, one bit per clock, using a full-adder cell built from two existing `half_adder` instances plus an OR gate, with a registered carry. It sits directly downstream of `half_adder`, consuming its `sum`/`carry` outputs to form multi-bit results. It exposes a start/busy/done handshake so lab top-levels and benches can drive it from switches or a stimulus FSM.

---
 rtl/serial_adder.sv | 150 +++++++++++++++
 tb/tb_serial_adder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder with start/busy/done handshake
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.

module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic             load, shift_en, busy_n, done_n, last_bit;
  logic [WIDTH-1:0] a_sr, b_sr, sum_r;
  logic             carry_r;
  logic [CW-1:0]    cnt;

  // Full-adder cell: two half adders plus an OR for the carry.
  logic s0, c0, cell_sum, c1, cell_carry;

  half_adder u_ha0 (
    .a     (a_sr[0]),
    .b     (b_sr[0]),
    .sum   (s0),
    .carry (c0)
  );

  half_adder u_ha1 (
    .a     (s0),
    .b     (carry_r),
    .sum   (cell_sum),
    .carry (c1)
  );

  assign cell_carry = c0 | c1;
  assign last_bit   = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_n  = state;
    load     = 1'b0;
    shift_en = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_SHIFT;
          load    = 1'b1;
        end
      end
      S_SHIFT: begin
        shift_en = 1'b1;
        if (last_bit) state_n = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          state_n = S_SHIFT;
          load    = 1'b1;
        end else begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n == S_SHIFT);
    done_n = (state_n == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  // Sum bits enter at the MSB so the result is aligned after WIDTH shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
      cnt     <= '0;
    end else if (load) begin
      a_sr    <= a;
      b_sr    <= b;
      sum_r   <= '0;
      carry_r <= 1'b0;
      cnt     <= '0;
    end else if (shift_en) begin
      a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
      sum_r   <= {cell_sum, sum_r[WIDTH-1:1]};
      carry_r <= cell_carry;
      cnt     <= cnt + CW'(1);
    end
  end

  assign sum       = sum_r;
  assign carry_out = carry_r;

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_r;

  // Signed overflow: carry into the MSB differs from carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_r <= 1'b0;
    end else if (load) begin
      ovf_r <= 1'b0;
    end else if (shift_en && last_bit) begin
      ovf_r <= carry_r ^ cell_carry;
    end
  end

  assign overflow = ovf_r;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - table-driven self-checking bench for serial_adder
// Overflow checks are compiled in when SERIAL_ADDER_OVF_EN is defined.

module tb_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       busy, done, carry_out;
  logic [7:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic       overflow;
`endif

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .overflow  (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;
    logic       c;
    logic       o;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_result(input string nm, input logic [7:0] es, input logic ec, input logic eo);
    check({nm, "_sum"}, 32'(sum), 32'(es));
    check({nm, "_cout"}, 32'(carry_out), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
    check({nm, "_ovf"}, 32'(overflow), 32'(eo));
`else
    if (eo === 1'bx) check({nm, "_ovf_vec"}, 32'(eo), 32'(0));
`endif
  endtask

  task automatic run_op(input string nm, input logic [7:0] ta, input logic [7:0] tb_,
                        input logic [7:0] es, input logic ec, input logic eo);
    int cyc;
    bit seen, bad, held;
    @(negedge clk);
    a = ta; b = tb_; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = '0; b = '0;
    check({nm, "_busy_at_accept"}, 32'(busy), 32'(1));
    cyc = 0; seen = 0; bad = 0;
    while (!seen && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (busy && done) bad = 1;
      if (done) seen = 1;
      else if (!busy) bad = 1;
    end
    check({nm, "_latency"}, 32'(cyc), 32'(8));
    check({nm, "_handshake"}, 32'(bad), 32'(0));
    check_result(nm, es, ec, eo);
    @(posedge clk); #1;
    check({nm, "_done_width"}, 32'(done), 32'(0));
    held = 1;
    repeat (5) begin
      @(posedge clk); #1;
      if (sum !== es || carry_out !== ec || busy !== 1'b0) held = 0;
    end
    check({nm, "_hold"}, 32'(held), 32'(1));
  endtask

  vec_t vecs[6];

  initial begin
    int cyc, ndone, last, bad;
    vecs[0] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1};
    vecs[3] = '{8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[4] = '{8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0};
    vecs[5] = '{8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    check_result("reset", 8'h00, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].c, vecs[i].o);

    // start pulsed mid-SHIFT with other operands must be ignored
    @(negedge clk); a = 8'h11; b = 8'h22; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); start = 1'b1; a = 8'hFF; b = 8'hFF;
    @(posedge clk); #1; start = 1'b0; a = '0; b = '0;
    cyc = 3;
    while (!done && cyc < 20) begin @(posedge clk); #1; cyc++; end
    check("ignore_latency", 32'(cyc), 32'(8));
    check_result("ignore", 8'h33, 1'b0, 1'b0);
    ndone = 0;
    repeat (12) begin @(posedge clk); #1; if (done) ndone++; end
    check("ignore_single_done", 32'(ndone), 32'(0));

    // start held continuously: one result every 9 cycles
    @(negedge clk); a = 8'h80; b = 8'h80; start = 1'b1;
    @(posedge clk); #1;
    ndone = 0; last = 0; bad = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (sum !== 8'h00 || carry_out !== 1'b1) bad++;
        if (ndone == 1 && i != 8) bad++;
        if (ndone > 1 && (i - last) != 9) bad++;
        last = i;
      end
    end
    check("held_done_count", 32'(ndone), 32'(4));
    check("held_results", 32'(bad), 32'(0));
    @(negedge clk); start = 1'b0; a = '0; b = '0;
    repeat (12) @(posedge clk);

    // reset mid-SHIFT
    @(negedge clk); a = 8'hAA; b = 8'h55; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; a = '0; b = '0;
    repeat (4) @(posedge clk);
    #1;
    check("partial_sum", 32'(sum), 32'(8'hF0));
    rst_n = 1'b0;
    #1;
    check("midreset_busy", 32'(busy), 32'(0));
    check("midreset_done", 32'(done), 32'(0));
    check_result("midreset", 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    ndone = 0; bad = 0;
    repeat (15) begin @(posedge clk); #1; if (done) ndone++; if (busy) bad++; end
    check("postreset_no_done", 32'(ndone), 32'(0));
    check("postreset_idle", 32'(bad), 32'(0));
    run_op("after_reset", 8'h01, 8'h02, 8'h03, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
